// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants for the sequential multiply/divide unit (multdiv_seq).
// Holds the state encodings, operation codes, the default iteration count and INT_MIN.
package multdiv_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ITER       = DATA_W_DEF;

    localparam logic [DATA_W_DEF-1:0] INT_MIN = 32'h8000_0000;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_MUL  = 3'd1;
    localparam state_t S_DIV  = 3'd2;
    localparam state_t S_FIX  = 3'd3;
    localparam state_t S_DONE = 3'd4;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: combinational W-bit adder/subtractor; sub_i inverts b_i and injects a carry-in.
// Shared by the Booth add/subtract step and the restoring-division trial subtract.
module multdiv_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    logic [W-1:0] b_eff;

    assign b_eff = b_i ^ {W{sub_i}};
    assign sum_o = a_i + b_eff + {{(W-1){1'b0}}, sub_i};

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit with a one-cycle ready pulse.
// Optional MULTDIV_EARLY_EXIT_EN: zero-operand operations skip the iterations and complete one edge after start.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int DATA_W = ITER
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W:0]   acc_q, acc_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic              qm1_q, qm1_d;
    logic              op_q, op_d;
    logic              neg_q, neg_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              exc_q, exc_d;
    logic              rdy_q, rdy_d;

    logic              start;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   as_a, as_b, as_sum;
    logic              as_sub;

    assign start     = ctrl_MULT | ctrl_DIV;
    assign abs_a     = data_operandA[DATA_W-1] ? -data_operandA : data_operandA;
    assign abs_b     = data_operandB[DATA_W-1] ? -data_operandB : data_operandB;
    assign div_shift = {acc_q[DATA_W-1:0], q_q[DATA_W-1]};

    // Booth uses {q[0], q-1} to pick +M / -M / nothing; division always trial-subtracts the divisor.
    always_comb begin
        as_a   = acc_q;
        as_b   = '0;
        as_sub = 1'b0;
        if (op_q == OP_DIV) begin
            as_a   = div_shift;
            as_b   = {1'b0, m_q};
            as_sub = 1'b1;
        end else begin
            case ({q_q[0], qm1_q})
                2'b01: as_b = {m_q[DATA_W-1], m_q};
                2'b10: begin
                    as_b   = {m_q[DATA_W-1], m_q};
                    as_sub = 1'b1;
                end
                default: ;
            endcase
        end
    end

    multdiv_addsub #(
        .W(DATA_W + 1)
    ) u_addsub (
        .a_i  (as_a),
        .b_i  (as_b),
        .sub_i(as_sub),
        .sum_o(as_sum)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        qm1_d    = qm1_q;
        op_d     = op_q;
        neg_d    = neg_q;
        err_d    = err_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start) begin
            // A start in any state restarts from scratch; an op in flight is dropped without ready.
            count_d = '0;
            acc_d   = '0;
            qm1_d   = 1'b0;
            op_d    = ctrl_MULT ? OP_MUL : OP_DIV;
            neg_d   = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            err_d   = (data_operandB == '0) ||
                      ((data_operandA == MIN_NEG) && (data_operandB == '1));
            if (ctrl_MULT) begin
                q_d     = data_operandB;
                m_d     = data_operandA;
                state_d = S_MUL;
            end else begin
                q_d     = abs_a;
                m_d     = abs_b;
                state_d = S_DIV;
            end
`ifdef MULTDIV_EARLY_EXIT_EN
            if ((data_operandA == '0) || (data_operandB == '0)) begin
                state_d  = S_DONE;
                result_d = '0;
                exc_d    = ~ctrl_MULT & (data_operandB == '0);
            end
`endif
        end else begin
            case (state_q)
                S_MUL: begin
                    acc_d   = {as_sum[DATA_W], as_sum[DATA_W:1]};
                    q_d     = {as_sum[0], q_q[DATA_W-1:1]};
                    qm1_d   = q_q[0];
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_LAST) state_d = S_FIX;
                end
                S_DIV: begin
                    if (as_sum[DATA_W]) begin
                        acc_d = div_shift;
                        q_d   = {q_q[DATA_W-2:0], 1'b0};
                    end else begin
                        acc_d = as_sum;
                        q_d   = {q_q[DATA_W-2:0], 1'b1};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_LAST) state_d = S_FIX;
                end
                S_FIX: begin
                    if (op_q == OP_MUL) begin
                        result_d = q_q;
                        exc_d    = (acc_q != {(DATA_W+1){q_q[DATA_W-1]}});
                    end else if (err_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = neg_q ? -q_q : q_q;
                        exc_d    = 1'b0;
                    end
                    state_d = S_DONE;
                end
                S_DONE: begin
                    rdy_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            qm1_q    <= qm1_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: scoreboard bench for multdiv_seq; expected result, exception and ready cycle
// are queued when an operation is started and compared when the ready pulse appears.
`timescale 1ns/1ps
module tb_multdiv_seq;

    localparam int DW       = 32;
    localparam int FULL_LAT = DW + 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] data_operandA;
    logic [DW-1:0] data_operandB;
    logic          ctrl_MULT;
    logic          ctrl_DIV;
    logic [DW-1:0] data_result;
    logic          data_exception;
    logic          data_resultRDY;

    always #5 clock = ~clock;

    multdiv_seq #(
        .DATA_W(DW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    typedef struct {
        logic [DW-1:0] res;
        logic          exc;
        int            cyc;
        string         tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    logic prev_rdy = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit early_en = 1'b0;
`ifdef MULTDIV_EARLY_EXIT_EN
        early_en = 1'b1;
`endif
        return (early_en && ((a == '0) || (b == '0))) ? 1 : FULL_LAT;
    endfunction

    task automatic model(input logic mul, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] r, output logic e);
        logic [63:0] p;
        int          quo;
        if (mul) begin
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            r = p[31:0];
            e = (p[63:32] != {32{p[31]}});
        end else if ((b == '0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))) begin
            r = '0;
            e = 1'b1;
        end else begin
            quo = $signed(a) / $signed(b);
            r   = quo;
            e   = 1'b0;
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (data_resultRDY === 1'b1) begin
            check_eq("rdy_single", {63'd0, prev_rdy}, 64'd0);
            if (sb.size() == 0) begin
                check_eq("spurious_rdy", {63'd0, data_resultRDY}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.tag, "_res"}, {32'd0, data_result}, {32'd0, mon_e.res});
                check_eq({mon_e.tag, "_exc"}, {63'd0, data_exception}, {63'd0, mon_e.exc});
                check_eq({mon_e.tag, "_lat"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
        prev_rdy <= data_resultRDY;
    end

    // Called at a negedge; the start is sampled on the following posedge (E0).
    task automatic start_op(input logic mul, input logic div,
                            input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] exp_res, input logic exp_exc,
                            input bit track, input string tag);
        exp_t e;
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        if (track) begin
            e.res = exp_res;
            e.exc = exp_exc;
            e.cyc = cyc + 1 + lat_of(a, b);
            e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((sb.size() != 0) && (n < bound)) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic run_model(input logic mul, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input string tag);
        logic [DW-1:0] r;
        logic          e;
        model(mul, a, b, r, e);
        start_op(mul, ~mul, a, b, r, e, 1'b1, tag);
        wait_drain(FULL_LAT + 10);
    endtask

    initial begin
        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        check_eq("reset_res", {32'd0, data_result}, 64'd0);
        check_eq("reset_exc", {63'd0, data_exception}, 64'd0);
        check_eq("reset_rdy", {63'd0, data_resultRDY}, 64'd0);
        reset = 1'b1;
        @(negedge clock);

        start_op(1, 0, 7, -3, 32'hFFFF_FFEB, 0, 1, "mul_7x-3");          wait_drain(50);
        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 0, 1, 1, "mul_ovf"); wait_drain(50);
        start_op(0, 1, -7, 2, 32'hFFFF_FFFD, 0, 1, "div_-7/2");           wait_drain(50);
        start_op(0, 1, 100, 7, 14, 0, 1, "div_100/7");                    wait_drain(50);
        start_op(0, 1, 5, 0, 0, 1, 1, "div_by0");                         wait_drain(50);
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 1, "div_min/-1"); wait_drain(50);
        start_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, "mul_minx-1"); wait_drain(50);
        start_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 1, 1, "mul_minxmin"); wait_drain(50);
        start_op(0, 1, 32'h8000_0000, 1, 32'h8000_0000, 0, 1, "div_min/1"); wait_drain(50);
        start_op(0, 1, 7, -2, 32'hFFFF_FFFD, 0, 1, "div_7/-2");           wait_drain(50);
        start_op(1, 0, -1, -1, 1, 0, 1, "mul_-1x-1");                     wait_drain(50);
        start_op(1, 0, 0, 32'h1234_5678, 0, 0, 1, "mul_zero");            wait_drain(50);
        start_op(0, 1, 0, 5, 0, 0, 1, "div_zero");                        wait_drain(50);

        // Restart while busy: the multiply must never report.
        start_op(1, 0, 3, 4, 12, 0, 0, "mul_aborted");
        repeat (9) @(negedge clock);
        start_op(0, 1, 20, 5, 4, 0, 1, "div_restart");
        wait_drain(60);

        // Asynchronous reset in the middle of a multiply.
        start_op(1, 0, 5, 6, 30, 0, 0, "mul_reset");
        repeat (14) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check_eq("async_rst_res", {32'd0, data_result}, 64'd0);
        check_eq("async_rst_exc", {63'd0, data_exception}, 64'd0);
        check_eq("async_rst_rdy", {63'd0, data_resultRDY}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        start_op(1, 1, -9, 11, -99, 0, 1, "both_mult_wins");
        wait_drain(50);

        for (int i = 0; i < 8; i++) begin
            run_model(1'b1, $urandom, $urandom, "rnd_mul");
            run_model(1'b0, $urandom, $urandom_range(1, 1000) * (($urandom & 1) ? 1 : -1), "rnd_div");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
